// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external RAM with a combinational read port.
// Pops register the RAM read word into rd_data; all flags derive from the registered count.
module sync_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 8,
    parameter int AFULL_TH  = (1 << DEPTH_LOG) - 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic [WIDTH-1:0]     wr_data,
    output logic                 full,
    output logic                 almost_full,
    input  logic                 rd_req,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 ram_write_req,
    output logic [DEPTH_LOG-1:0] ram_write_addr,
    output logic [WIDTH-1:0]     ram_write_data,
    output logic [DEPTH_LOG-1:0] ram_read_addr,
    input  logic [WIDTH-1:0]     ram_read_data
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [DEPTH_LOG:0] wptr, rptr;
    logic               push_ok, pop_ok;

    assign full        = (count == (DEPTH_LOG+1)'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (int'(count) >= AFULL_TH);

    // Both requests are judged against the pre-edge flags, so no full/empty bypass.
    assign push_ok = wr_req && !full  && !rst;
    assign pop_ok  = rd_req && !empty && !rst;

    assign ram_write_req  = push_ok;
    assign ram_write_addr = wptr[DEPTH_LOG-1:0];
    assign ram_write_data = wr_data;
    assign ram_read_addr  = rptr[DEPTH_LOG-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_req && full;
            underflow <= rd_req && empty;
            rd_valid  <= pop_ok;
            if (push_ok)
                wptr <= wptr + (DEPTH_LOG+1)'(1);
            if (pop_ok) begin
                rptr    <= rptr + (DEPTH_LOG+1)'(1);
                rd_data <= ram_read_data;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (DEPTH_LOG+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl at depth 4: directed scenarios then random traffic,
// every cycle compared against a queue-based model of FIFO behaviour.
module tb_sync_fifo_ctrl;
    localparam int WIDTH = 8;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;
    localparam int AFTH  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_req, rd_req;
    logic [WIDTH-1:0] wr_data;
    logic             full, almost_full, empty, rd_valid, overflow, underflow;
    logic [WIDTH-1:0] rd_data, ram_write_data, ram_read_data;
    logic [DL:0]      count;
    logic             ram_write_req;
    logic [DL-1:0]    ram_write_addr, ram_read_addr;

    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // model state
    logic [WIDTH-1:0] q[$];
    int               m_wa, m_ra;
    logic [WIDTH-1:0] m_rd_data;
    logic             m_rd_valid, m_ov, m_un;

    sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH_LOG(DL), .AFULL_TH(AFTH)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .ram_write_req(ram_write_req), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_read_addr(ram_read_addr),
        .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_write_req) mem[ram_write_addr] <= ram_write_data;
    assign ram_read_data = mem[ram_read_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational RAM side, clock, advance model, check registered side.
    task automatic step(input logic r, input logic wr, input logic [WIDTH-1:0] wd, input logic rd);
        bit m_full, m_empty, push, pop;
        @(negedge clk);
        rst = r; wr_req = wr; wr_data = wd; rd_req = rd;
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        push = !r && wr && !m_full;
        pop  = !r && rd && !m_empty;
        #1;
        chk("ram_write_req", 32'(ram_write_req), 32'(push));
        chk("ram_read_addr", 32'(ram_read_addr), 32'(m_ra));
        if (push) begin
            chk("ram_write_addr", 32'(ram_write_addr), 32'(m_wa));
            chk("ram_write_data", 32'(ram_write_data), 32'(wd));
        end
        @(posedge clk);
        if (r) begin
            q.delete(); m_wa = 0; m_ra = 0;
            m_rd_data = '0; m_rd_valid = 0; m_ov = 0; m_un = 0;
        end else begin
            m_ov = wr && m_full;
            m_un = rd && m_empty;
            m_rd_valid = pop;
            if (pop) begin
                m_rd_data = q.pop_front();
                m_ra = (m_ra + 1) % DEPTH;
            end
            if (push) begin
                q.push_back(wd);
                m_wa = (m_wa + 1) % DEPTH;
            end
        end
        #1;
        chk("count",       32'(count),       32'(q.size()));
        chk("empty",       32'(empty),       32'(q.size() == 0));
        chk("full",        32'(full),        32'(q.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AFTH));
        chk("rd_valid",    32'(rd_valid),    32'(m_rd_valid));
        chk("rd_data",     32'(rd_data),     32'(m_rd_data));
        chk("overflow",    32'(overflow),    32'(m_ov));
        chk("underflow",   32'(underflow),   32'(m_un));
    endtask

    initial begin
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        m_wa = 0; m_ra = 0; m_rd_data = '0; m_rd_valid = 0; m_ov = 0; m_un = 0;
        step(1, 0, 8'h00, 0);
        step(1, 1, 8'h5a, 1);              // requests ignored during reset

        // three pushes then three pops
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // fill, overflow, push+pop while full
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hA0 + i), 0);
        step(0, 1, 8'hEE, 0);
        step(0, 1, 8'hEF, 1);
        // refill and drain across the address wrap
        for (int r = 0; r < 3; r++) begin
            while (q.size() < DEPTH) step(0, 1, 8'($urandom), 0);
            while (q.size() > 0)     step(0, 0, 8'h00, 1);
        end

        // push+pop while empty, then pop the word
        step(0, 1, 8'h77, 1);
        step(0, 0, 8'h00, 1);

        // reset with two words stored, then pop
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55,
                 8'($urandom), $urandom_range(0, 99) < 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG, default 8, log2 of storage depth; DEPTH = 2**DEPTH_LOG.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-4, occupancy at or above which almost_full asserts.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_req  input  1  push request.
REQ-007 SHALL have port wr_data  input  WIDTH  push data.
REQ-008 SHALL have port full  output  1  occupancy == DEPTH.
REQ-009 SHALL have port almost_full  output  1  occupancy >= AFULL_TH.
REQ-010 SHALL have port rd_req  input  1  pop request.
REQ-011 SHALL have port rd_data  output  WIDTH  registered pop data.
REQ-012 SHALL have port rd_valid  output  1  rd_data valid, one-cycle pulse per accepted pop.
REQ-013 SHALL have port empty  output  1  occupancy == 0.
REQ-014 SHALL have port count  output  DEPTH_LOG+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse, rejected push.
REQ-016 SHALL have port underflow  output  1  one-cycle pulse, rejected pop.
REQ-017 SHALL have port ram_write_req  output  1  RAM write enable.
REQ-018 SHALL have port ram_write_addr  output  DEPTH_LOG  RAM write address.
REQ-019 SHALL have port ram_write_data  output  WIDTH  RAM write data.
REQ-020 SHALL have port ram_read_addr  output  DEPTH_LOG  RAM read address.
REQ-021 SHALL have port ram_read_data  input  WIDTH  RAM read data; combinational from ram_read_addr, same cycle.

Function
REQ-022 SHALL keep write pointer wptr and read pointer rptr, each DEPTH_LOG+1 bits, incrementing mod 2**(DEPTH_LOG+1); RAM addresses are the low DEPTH_LOG bits (wrap DEPTH-1 -> 0).
REQ-023 SHALL accept a push when wr_req=1 and full=0 at the clock edge: ram_write_req=1 combinationally, ram_write_addr=wptr[DEPTH_LOG-1:0], ram_write_data=wr_data, wptr+1 at the edge.
REQ-024 SHALL drive ram_write_req=0 whenever wr_req=0 or full=1; a push while full is dropped, no state change.
REQ-025 SHALL drive ram_read_addr=rptr[DEPTH_LOG-1:0] continuously.
REQ-026 SHALL accept a pop when rd_req=1 and empty=0: rd_data<=ram_read_data, rd_valid<=1, rptr+1 at the edge; latency one cycle from request edge to rd_valid.
REQ-027 SHALL hold rd_data unchanged when no pop is accepted; rd_valid=0 that cycle.
REQ-028 SHALL update count registered: +1 push only, -1 pop only, unchanged for both or neither; full/empty/almost_full derived from registered count.
REQ-029 SHALL, on simultaneous push and pop, evaluate both against pre-edge flags: when full, pop accepted and push rejected; when empty, push accepted and pop rejected (no bypass; word popable the following cycle).
REQ-030 SHALL, on simultaneous accepted push and pop at 0<count<DEPTH, keep count constant and advance both pointers.
REQ-031 SHALL pulse overflow for one cycle, registered, the cycle after wr_req=1 with full=1; underflow likewise for rd_req=1 with empty=1.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, set wptr=0, rptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; empty=1, full=0, almost_full=0 thereafter.
REQ-033 SHALL, while rst=1, hold ram_write_req=0 and ignore wr_req/rd_req; reset mid-operation discards all stored words (RAM contents not cleared).
REQ-034 SHALL accept requests on the first edge after rst deasserts.

Verification
REQ-035 Reset then push 0x11,0x22,0x33 on 3 cycles -> ram_write_addr 0,1,2 with ram_write_req=1; count=3, empty=0.
REQ-036 Pop 3 times -> rd_valid pulses with rd_data 0x11,0x22,0x33, one cycle after each request; empty=1, count=0.
REQ-037 DEPTH_LOG=2: push 4 words -> full=1, almost_full=1 (AFULL_TH=2); 5th push -> ram_write_req=0, overflow pulse, count stays 4.
REQ-038 DEPTH_LOG=2, full: push+pop same cycle -> pop returns oldest word, push dropped, count=3; refill and drain 3 rounds -> address wrap 3->0 with data order preserved.
REQ-039 Empty: push+pop same cycle -> underflow pulse, rd_valid=0, count=1; next-cycle pop returns pushed word.
REQ-040 count=2, assert rst for one cycle -> count=0, empty=1, rd_valid=0; a following pop -> underflow pulse.
